// File: rtl/multi_seq_det.sv
// Serial detector for NUM_PAT runtime-programmable bit patterns (1..SEQ_LEN bits each).
// Optional per-slot saturating hit counters are built when MULTI_SEQ_CNT_EN is defined.
module multi_seq_det #(
  parameter int NUM_PAT = 2,
  parameter int SEQ_LEN = 4,
  parameter int CNT_W   = 8,
  localparam int LEN_W  = $clog2(SEQ_LEN + 1),
  localparam int IDX_W  = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               din_valid,
  input  logic               din,
  input  logic               overlap,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic               cfg_en,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic [SEQ_LEN-1:0] cfg_pat,
  output logic [NUM_PAT-1:0] detected
`ifdef MULTI_SEQ_CNT_EN
  ,
  output logic [NUM_PAT*CNT_W-1:0] hit_cnt
`endif
);

  // The oldest history bit only ever shifts out, so it is not stored.
  logic [SEQ_LEN-2:0] hist_reg;
  logic [LEN_W-1:0]   fill_reg;
  logic [NUM_PAT-1:0] det_reg;

  logic               en_reg  [NUM_PAT];
  logic [LEN_W-1:0]   len_reg [NUM_PAT];
  logic [SEQ_LEN-1:0] pat_reg [NUM_PAT];

  logic [SEQ_LEN-1:0] nh;
  logic [LEN_W-1:0]   nf;
  logic [NUM_PAT-1:0] match;

  assign nh = {hist_reg, din};
  assign nf = (fill_reg == LEN_W'(SEQ_LEN)) ? fill_reg : fill_reg + 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PAT; gi++) begin : g_slot
      logic slot_hit;
      // len <= nf also bounds len to SEQ_LEN, so oversize lengths never match.
      always_comb begin
        slot_hit = 1'b0;
        if (en_reg[gi] && (len_reg[gi] != '0) && (len_reg[gi] <= nf)) begin
          slot_hit = 1'b1;
          for (int k = 0; k < SEQ_LEN; k++) begin
            if ((k < int'(len_reg[gi])) && (nh[k] != pat_reg[gi][k])) begin
              slot_hit = 1'b0;
            end
          end
        end
      end
      assign match[gi] = slot_hit;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_reg <= '0;
      fill_reg <= '0;
      det_reg  <= '0;
    end else if (clear) begin
      hist_reg <= '0;
      fill_reg <= '0;
      det_reg  <= '0;
    end else begin
      det_reg <= din_valid ? match : '0;
      if (din_valid) begin
        hist_reg <= nh[SEQ_LEN-2:0];
        fill_reg <= (!overlap && (|match)) ? '0 : nf;
      end
    end
  end

  // Configuration survives clear; only reset wipes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_PAT; i++) begin
        en_reg[i]  <= 1'b0;
        len_reg[i] <= '0;
        pat_reg[i] <= '0;
      end
    end else if (cfg_we) begin
      for (int i = 0; i < NUM_PAT; i++) begin
        if (int'(cfg_idx) == i) begin
          en_reg[i]  <= cfg_en;
          len_reg[i] <= cfg_len;
          pat_reg[i] <= cfg_pat;
        end
      end
    end
  end

  assign detected = det_reg;

`ifdef MULTI_SEQ_CNT_EN
  logic [CNT_W-1:0] cnt_reg [NUM_PAT];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_PAT; i++) cnt_reg[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < NUM_PAT; i++) cnt_reg[i] <= '0;
    end else if (din_valid) begin
      for (int i = 0; i < NUM_PAT; i++) begin
        if (match[i] && (cnt_reg[i] != '1)) cnt_reg[i] <= cnt_reg[i] + 1'b1;
      end
    end
  end

  generate
    for (gi = 0; gi < NUM_PAT; gi++) begin : g_cnt
      assign hit_cnt[gi*CNT_W +: CNT_W] = cnt_reg[gi];
    end
  endgenerate
`endif

endmodule
